mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter: LATENCY, 32, rising edges from mul_start sampled by the multiplier until product valid (range 2..63).
REQ-002 SHALL have parameter: CNT_W, 6, width of cycle counter.
REQ-003 SHALL have port: clk  input  1  single clock, rising-edge active.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: mul_req  input  1  pipeline requests unsigned multiply of op_a x op_b.
REQ-006 SHALL have port: op_a, op_b  input  32 each  multiply operands, valid with mul_req.
REQ-007 SHALL have port: mfhi_req, mflo_req  input  1 each  pipeline read of HI / LO.
REQ-008 SHALL have port: mt_we  input  1  write mt_data into HI (mt_sel=1) or LO (mt_sel=0).
REQ-009 SHALL have port: mt_sel  input  1, and mt_data  input  32.
REQ-010 SHALL have port: flush  input  1  pipeline flush, aborts an in-flight multiply.
REQ-011 SHALL have port: mul_prod  input  64  product from multiplier datapath.
REQ-012 SHALL have port: mul_start  output  1  one-cycle start pulse to multiplier.
REQ-013 SHALL have port: mul_a, mul_b  output  32 each  registered operands driven to multiplier.
REQ-014 SHALL have port: busy  output  1, stall  output  1, done  output  1.
REQ-015 SHALL have port: hi, lo  output  32 each  architectural HI/LO registers.
REQ-016 SHALL have port: rd_data  output  32  result of mfhi/mflo.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; busy = (state != IDLE).
REQ-018 IDLE: mul_req=1 SHALL latch op_a/op_b into mul_a/mul_b and go to ISSUE; otherwise stay.
REQ-019 ISSUE: mul_start SHALL be 1 for exactly this cycle; next state WAIT with cnt=0.
REQ-020 WAIT: cnt SHALL increment each edge; at the edge where cnt==LATENCY-1, {hi,lo} <= mul_prod and state -> DONE.
REQ-021 DONE: done SHALL be 1 for exactly this cycle; next state IDLE.
REQ-022 Latency: mul_req sampled at edge R -> hi/lo updated at edge R+1+LATENCY, done high in cycle after, IDLE after edge R+2+LATENCY.
REQ-023 stall SHALL be combinational = (state is ISSUE or WAIT) & (mfhi_req|mflo_req|mt_we|mul_req), plus (state==DONE & mul_req).
REQ-024 mul_req seen while busy SHALL not be latched; requester holds it until stall drops.
REQ-025 rd_data SHALL be combinational: hi when mfhi_req, else lo when mflo_req, else 0; mfhi has priority; value valid only when stall=0.
REQ-026 mt_we with stall=0 SHALL update the selected register at the edge; the other register is unchanged.
REQ-027 In IDLE, simultaneous mfhi/mflo and mul_req SHALL return old hi/lo and accept the multiply.
REQ-028 In IDLE, simultaneous mt_we and mul_req SHALL apply mt_we; the later product overwrites both.
REQ-029 flush in ISSUE or WAIT SHALL return to IDLE at the next edge, cnt=0, hi/lo unchanged, done not asserted.
REQ-030 flush in IDLE or DONE SHALL have no effect.
REQ-031 Arithmetic SHALL be unsigned; no product modification; cnt SHALL never wrap within an operation.

Reset
REQ-032 reset=1 SHALL immediately force state=IDLE, cnt=0, mul_start=0, done=0, busy=0, mul_a=mul_b=0, hi=lo=0.
REQ-033 reset asserted mid-operation SHALL discard the operation; no hi/lo update after release.
REQ-034 stall and rd_data SHALL evaluate from reset-state registers while reset=1, giving stall=0 and rd_data=0.

Verification
REQ-035 Multiply 3 x 5, LATENCY=32 -> mul_start one pulse, hi=0x00000000, lo=0x0000000F at edge R+33, done one cycle.
REQ-036 Multiply 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 34 cycles.
REQ-037 mflo_req held from cycle 5 of WAIT -> stall=1 until DONE; in DONE stall=0, rd_data = new lo.
REQ-038 mthi 0x1234 in IDLE, then multiply, flush at cnt=10 -> IDLE next edge, hi=0x1234, lo=0, no done.
REQ-039 reset pulse at cnt=20 -> all outputs zero immediately; new 7 x 6 afterwards -> lo=42.
REQ-040 mul_req held during busy -> stall=1, mul_start single pulse per accepted request, second multiply starts after IDLE.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl
//
// Sequencing controller for a multi-cycle unsigned 32x32 multiplier. It sits
// between the pipeline and an external multiplier datapath, and owns the
// architectural HI/LO registers.
//
// A multiply request is accepted only when the controller is idle. The
// operands are latched and the multiplier gets a one-cycle start pulse.
// The controller then counts LATENCY rising edges before it captures the
// 64-bit product into {hi,lo}. A one-cycle done pulse follows.
//
// While the multiplier is busy, the pipeline is stalled on any access to
// HI/LO and on any new multiply request. A flush abandons an in-flight
// multiply without touching HI/LO.
//
// Parameters
//   LATENCY  rising edges, counted from the sampled start pulse, until
//            mul_prod is valid (2..63)
//   CNT_W    width of the wait counter
//
// Ports
//   clk        in   1   clock, rising-edge active
//   reset      in   1   asynchronous active-high reset
//   mul_req    in   1   pipeline requests op_a * op_b (unsigned)
//   op_a/op_b  in   32  multiply operands, valid with mul_req
//   mfhi_req   in   1   pipeline read of HI
//   mflo_req   in   1   pipeline read of LO
//   mt_we      in   1   write mt_data into HI (mt_sel=1) or LO (mt_sel=0)
//   mt_sel     in   1   HI/LO select for mt_we
//   mt_data    in   32  data for mt_we
//   flush      in   1   pipeline flush, aborts an in-flight multiply
//   mul_prod   in   64  product from the multiplier datapath
//   mul_start  out  1   one-cycle start pulse to the multiplier
//   mul_a/b    out  32  registered operands driven to the multiplier
//   busy       out  1   controller is not idle
//   stall      out  1   pipeline must hold its current HI/LO/multiply access
//   done       out  1   one-cycle pulse after the product lands in HI/LO
//   hi/lo      out  32  architectural HI/LO registers
//   rd_data    out  32  result of mfhi/mflo (valid only while stall=0)
// ---------------------------------------------------------------------------
module mul_seq_ctrl #(
  parameter int LATENCY = 32,
  parameter int CNT_W   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mul_req,
  input  logic [31:0]   op_a,
  input  logic [31:0]   op_b,
  input  logic          mfhi_req,
  input  logic          mflo_req,
  input  logic          mt_we,
  input  logic          mt_sel,
  input  logic [31:0]   mt_data,
  input  logic          flush,
  input  logic [63:0]   mul_prod,
  output logic          mul_start,
  output logic [31:0]   mul_a,
  output logic [31:0]   mul_b,
  output logic          busy,
  output logic          stall,
  output logic          done,
  output logic [31:0]   hi,
  output logic [31:0]   lo,
  output logic [31:0]   rd_data
);

  // Reject parameter combinations where the counter cannot reach its
  // terminal value or where the latency is outside the supported range.
  if (LATENCY < 2 || LATENCY > 63) begin : g_bad_latency
    $error("mul_seq_ctrl: LATENCY must be in 2..63");
  end
  if ((LATENCY - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("mul_seq_ctrl: CNT_W too narrow for LATENCY");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Count value at which the product becomes valid on mul_prod.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;
  logic             prod_load;
  logic             mt_write;
  logic             in_flight;
  logic             hilo_access;

  // Status decodes. "In flight" covers the cycles where the multiplier owns
  // the result, so HI/LO may be about to change underneath the pipeline.
  // mul_start and done are pure state decodes, so the asynchronous reset
  // clears them the moment it moves the state to IDLE.
  always_comb begin
    in_flight   = (state == ISSUE) || (state == WAIT);
    hilo_access = mfhi_req | mflo_req | mt_we | mul_req;
    busy        = (state != IDLE);
    mul_start   = (state == ISSUE);
    done        = (state == DONE);
  end

  // Stall the pipeline on any HI/LO access or new multiply while a multiply
  // is in flight. In DONE the new HI/LO are already architectural, so reads
  // and writes may proceed; only a new multiply waits until IDLE.
  always_comb begin
    stall = (in_flight & hilo_access) | ((state == DONE) & mul_req);
  end

  // Qualified actions for this cycle. A product capture is dropped when a
  // flush arrives at the very last wait cycle, which keeps the "flush leaves
  // HI/LO untouched" rule true at every count. mt writes only go through
  // while the pipeline is not stalled, so they never collide with a capture.
  always_comb begin
    accept    = (state == IDLE) & mul_req;
    prod_load = (state == WAIT) & ~flush & (cnt == CNT_LAST);
    mt_write  = mt_we & ~stall;
  end

  // Read mux for mfhi/mflo. mfhi wins if both are asserted; with no read
  // request the bus is driven to zero rather than left floating.
  always_comb begin
    if (mfhi_req) begin
      rd_data = hi;
    end else if (mflo_req) begin
      rd_data = lo;
    end else begin
      rd_data = 32'd0;
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> DONE sequence. The
  // counter is cleared on leaving WAIT so it always starts the next
  // operation from zero and can never wrap inside one operation.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (mul_req) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt = '0;
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and wait counter. Reset abandons any operation immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operand registers feeding the multiplier. They are loaded only when a
  // request is accepted, so they stay stable for the whole operation even
  // if the requester changes op_a/op_b while it is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a <= 32'd0;
      mul_b <= 32'd0;
    end else if (accept) begin
      mul_a <= op_a;
      mul_b <= op_b;
    end
  end

  // Architectural HI/LO. The product is taken unmodified. An mt write
  // accepted in the same IDLE cycle as a multiply lands first; the product
  // overwrites both halves later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (prod_load) begin
      hi <= mul_prod[63:32];
      lo <= mul_prod[31:0];
    end else if (mt_write) begin
      if (mt_sel) begin
        hi <= mt_data;
      end else begin
        lo <= mt_data;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_ctrl
//
// Self-checking bench for mul_seq_ctrl. A behavioural multiplier presents
// the product on mul_prod only once LATENCY edges have passed since it
// sampled mul_start; before that it presents a garbage pattern. Expected
// products go into a scoreboard queue when a request is driven, and they are
// popped when the controller raises done.
// ---------------------------------------------------------------------------
module tb_mul_seq_ctrl;

  localparam int LAT = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mul_req = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        mfhi_req = 1'b0;
  logic        mflo_req = 1'b0;
  logic        mt_we = 1'b0;
  logic        mt_sel = 1'b0;
  logic [31:0] mt_data = '0;
  logic        flush = 1'b0;
  logic [63:0] mul_prod;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  logic [63:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_prod;

  mul_seq_ctrl #(.LATENCY(LAT), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .mul_req(mul_req), .op_a(op_a), .op_b(op_b),
    .mfhi_req(mfhi_req), .mflo_req(mflo_req), .mt_we(mt_we), .mt_sel(mt_sel),
    .mt_data(mt_data), .flush(flush), .mul_prod(mul_prod),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .busy(busy),
    .stall(stall), .done(done), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier datapath: the product is valid from the edge
  // LATENCY counts after mul_start was sampled.
  int          pcnt;
  logic [63:0] pend;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= 0;
      pend <= '0;
    end else if (mul_start) begin
      pcnt <= 1;
      pend <= 64'(mul_a) * 64'(mul_b);
    end else if (pcnt != 0) begin
      pcnt <= pcnt + 1;
    end
  end
  assign mul_prod = (pcnt >= LAT) ? pend : 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired n_cmp=%0d", n_cmp);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one multiply from IDLE and follows it to done. Index i counts
  // edges since acceptance, so done is expected at i = LAT+2.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output int done_at, output int starts,
                         output int busy_cyc, output logic [63:0] pre,
                         output logic [63:0] post_accept,
                         output logic [63:0] got, output logic [63:0] exp,
                         output logic busy_after, output logic done_after);
    op_a = a;
    op_b = b;
    mul_req = 1'b1;
    sb.push_back(64'(a) * 64'(b));
    tick();
    mul_req = 1'b0;
    mt_we = 1'b0;
    mfhi_req = 1'b0;
    mflo_req = 1'b0;
    post_accept = {hi, lo};
    done_at = -1;
    starts = 0;
    busy_cyc = 0;
    pre = '0;
    got = '0;
    exp = '0;
    for (int i = 1; i <= LAT + 10; i++) begin
      if (busy) busy_cyc++;
      if (mul_start) starts++;
      if (i == LAT + 1) pre = {hi, lo};
      if (done) begin
        done_at = i;
        got = {hi, lo};
        break;
      end
      tick();
    end
    if (sb.size() > 0) exp = sb.pop_front();
    tick();
    busy_after = busy;
    done_after = done;
  endtask

  task automatic test_reset();
    mfhi_req = 1'b1;
    mul_req = 1'b1;
    #12;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (mul_start !== 1'b0) begin n_err++; $display("[TB] FAIL reset_start got %b want 0", mul_start); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("[TB] FAIL reset_hilo got %h want 0", {hi, lo}); end
    n_cmp++; if ({mul_a, mul_b} !== 64'd0) begin n_err++; $display("[TB] FAIL reset_ops got %h want 0", {mul_a, mul_b}); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("[TB] FAIL reset_rd got %h want 0", rd_data); end
    mfhi_req = 1'b0;
    mul_req = 1'b0;
    #4;
    reset = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int d, s, bc;
    logic [63:0] pre, pa, got, exp;
    logic ba, da;
    run_mul(32'd3, 32'd5, d, s, bc, pre, pa, got, exp, ba, da);
    n_cmp++; if (d !== LAT + 2) begin n_err++; $display("[TB] FAIL basic_done_at got %0d want %0d", d, LAT + 2); end
    n_cmp++; if (s !== 1) begin n_err++; $display("[TB] FAIL basic_starts got %0d want 1", s); end
    n_cmp++; if (pre !== 64'd0) begin n_err++; $display("[TB] FAIL basic_early_hilo got %h want 0", pre); end
    n_cmp++; if (got !== exp) begin n_err++; $display("[TB] FAIL basic_sb got %h want %h", got, exp); end
    n_cmp++; if (got !== 64'h0000_0000_0000_000F) begin n_err++; $display("[TB] FAIL basic_prod got %h want f", got); end
    n_cmp++; if ({ba, da} !== 2'b00) begin n_err++; $display("[TB] FAIL basic_after got busy/done %b want 00", {ba, da}); end
  endtask

  task automatic test_max();
    int d, s, bc;
    logic [63:0] pre, pa, got, exp;
    logic ba, da;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, d, s, bc, pre, pa, got, exp, ba, da);
    n_cmp++; if (got !== exp) begin n_err++; $display("[TB] FAIL max_sb got %h want %h", got, exp); end
    n_cmp++; if (got !== 64'hFFFF_FFFE_0000_0001) begin n_err++; $display("[TB] FAIL max_prod got %h want fffffffe00000001", got); end
    n_cmp++; if (bc !== LAT + 2) begin n_err++; $display("[TB] FAIL max_busy_cycles got %0d want %0d", bc, LAT + 2); end
    n_cmp++; if (pre !== 64'hF) begin n_err++; $display("[TB] FAIL max_early_hilo got %h want f", pre); end
  endtask

  task automatic test_read_stall();
    int bad = 0;
    int seen = -1;
    logic [63:0] exp;
    logic st_done;
    logic [31:0] rd_done;
    op_a = 32'h1234_5678;
    op_b = 32'h9ABC_DEF0;
    mul_req = 1'b1;
    sb.push_back(64'(op_a) * 64'(op_b));
    tick();
    mul_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    mflo_req = 1'b1;
    #1;
    st_done = 1'b1;
    rd_done = '0;
    for (int i = 0; i < LAT + 10; i++) begin
      if (done) begin
        seen = i;
        st_done = stall;
        rd_done = rd_data;
        break;
      end
      if (stall !== 1'b1) bad++;
      tick();
    end
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    last_prod = exp;
    n_cmp++; if (seen < 0) begin n_err++; $display("[TB] FAIL rdst_done_seen got none want done"); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("[TB] FAIL rdst_stall_wait got %0d unstalled want 0", bad); end
    n_cmp++; if (st_done !== 1'b0) begin n_err++; $display("[TB] FAIL rdst_stall_done got %b want 0", st_done); end
    n_cmp++; if (rd_done !== exp[31:0]) begin n_err++; $display("[TB] FAIL rdst_rd_lo got %h want %h", rd_done, exp[31:0]); end
    mflo_req = 1'b0;
    tick();
    mfhi_req = 1'b1;
    mflo_req = 1'b1;
    #1;
    n_cmp++; if (rd_data !== exp[63:32]) begin n_err++; $display("[TB] FAIL rdst_hi_prio got %h want %h", rd_data, exp[63:32]); end
    mfhi_req = 1'b0;
    mflo_req = 1'b0;
    #1;
    n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("[TB] FAIL rdst_rd_idle got %h want 0", rd_data); end
  endtask

  task automatic test_idle_combo();
    int d, s, bc;
    logic [63:0] pre, pa, got, exp;
    logic ba, da;
    mfhi_req = 1'b1;
    mt_we = 1'b1;
    mt_sel = 1'b0;
    mt_data = 32'h0000_ABCD;
    op_a = 32'h0001_0000;
    op_b = 32'h0001_0000;
    mul_req = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("[TB] FAIL combo_stall got %b want 0", stall); end
    n_cmp++; if (rd_data !== last_prod[63:32]) begin n_err++; $display("[TB] FAIL combo_old_hi got %h want %h", rd_data, last_prod[63:32]); end
    run_mul(32'h0001_0000, 32'h0001_0000, d, s, bc, pre, pa, got, exp, ba, da);
    n_cmp++; if (pa !== {last_prod[63:32], 32'h0000_ABCD}) begin n_err++; $display("[TB] FAIL combo_mt got %h want %h", pa, {last_prod[63:32], 32'h0000_ABCD}); end
    n_cmp++; if (got !== 64'h0000_0001_0000_0000) begin n_err++; $display("[TB] FAIL combo_prod got %h want 100000000", got); end
    n_cmp++; if (got !== exp) begin n_err++; $display("[TB] FAIL combo_sb got %h want %h", got, exp); end
  endtask

  task automatic test_mt_flush();
    int dones = 0;
    int changes = 0;
    mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'h0000_5555;
    tick();
    n_cmp++; if ({hi, lo} !== 64'h0000_0001_0000_5555) begin n_err++; $display("[TB] FAIL mtlo got %h want 0000000100005555", {hi, lo}); end
    mt_sel = 1'b1; mt_data = 32'h0000_1234;
    tick();
    n_cmp++; if ({hi, lo} !== 64'h0000_1234_0000_5555) begin n_err++; $display("[TB] FAIL mthi got %h want 0000123400005555", {hi, lo}); end
    mt_sel = 1'b0; mt_data = 32'h0;
    tick();
    mt_we = 1'b0;
    op_a = 32'd9;
    op_b = 32'd9;
    mul_req = 1'b1;
    tick();
    mul_req = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    flush = 1'b1;
    mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("[TB] FAIL flush_mt_stall got %b want 1", stall); end
    tick();
    flush = 1'b0;
    mt_we = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL flush_idle got busy %b want 0", busy); end
    n_cmp++; if ({hi, lo} !== 64'h0000_1234_0000_0000) begin n_err++; $display("[TB] FAIL flush_hilo got %h want 0000123400000000", {hi, lo}); end
    for (int i = 0; i < LAT + 5; i++) begin
      if (done) dones++;
      if ({hi, lo} !== 64'h0000_1234_0000_0000) changes++;
      tick();
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("[TB] FAIL flush_no_done got %0d want 0", dones); end
    n_cmp++; if (changes !== 0) begin n_err++; $display("[TB] FAIL flush_hilo_hold got %0d changes want 0", changes); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int nonzero = 0;
    int d, s, bc;
    logic [63:0] pre, pa, got, exp;
    logic ba, da;
    op_a = 32'd11;
    op_b = 32'd13;
    mul_req = 1'b1;
    tick();
    mul_req = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    mflo_req = 1'b1;
    mul_req = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({busy, mul_start, done} !== 3'b000) begin n_err++; $display("[TB] FAIL rstmid_ctrl got %b want 000", {busy, mul_start, done}); end
    n_cmp++; if ({hi, lo, mul_a, mul_b} !== 128'd0) begin n_err++; $display("[TB] FAIL rstmid_regs got %h want 0", {hi, lo, mul_a, mul_b}); end
    n_cmp++; if ({stall, rd_data} !== 33'd0) begin n_err++; $display("[TB] FAIL rstmid_stall_rd got %h want 0", {stall, rd_data}); end
    mflo_req = 1'b0;
    mul_req = 1'b0;
    #2 reset = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      tick();
      if (done) dones++;
      if ({hi, lo} !== 64'd0) nonzero++;
    end
    n_cmp++; if ({dones, nonzero} !== 64'd0) begin n_err++; $display("[TB] FAIL rstmid_discard got dones=%0d nonzero=%0d want 0/0", dones, nonzero); end
    run_mul(32'd7, 32'd6, d, s, bc, pre, pa, got, exp, ba, da);
    n_cmp++; if (got !== 64'd42) begin n_err++; $display("[TB] FAIL rstmid_7x6 got %h want 2a", got); end
    n_cmp++; if (got !== exp) begin n_err++; $display("[TB] FAIL rstmid_sb got %h want %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int starts = 0;
    int seen = -1;
    int d, s, bc;
    logic [63:0] got1, exp1, pre, pa, got, exp;
    logic ba, da;
    got1 = '0;
    op_a = 32'd2;
    op_b = 32'd3;
    mul_req = 1'b1;
    sb.push_back(64'd6);
    tick();
    op_a = 32'd4;
    op_b = 32'd5;
    for (int i = 1; i <= LAT + 2; i++) begin
      if (stall !== 1'b1) bad++;
      if (mul_start) starts++;
      if (done && seen < 0) begin
        seen = i;
        got1 = {hi, lo};
      end
      tick();
    end
    exp1 = (sb.size() > 0) ? sb.pop_front() : '0;
    n_cmp++; if (bad !== 0) begin n_err++; $display("[TB] FAIL b2b_stall got %0d unstalled want 0", bad); end
    n_cmp++; if (starts !== 1) begin n_err++; $display("[TB] FAIL b2b_starts got %0d want 1", starts); end
    n_cmp++; if (seen !== LAT + 2) begin n_err++; $display("[TB] FAIL b2b_done_at got %0d want %0d", seen, LAT + 2); end
    n_cmp++; if (got1 !== exp1) begin n_err++; $display("[TB] FAIL b2b_first got %h want %h", got1, exp1); end
    n_cmp++; if ({busy, stall, mul_start} !== 3'b000) begin n_err++; $display("[TB] FAIL b2b_idle got %b want 000", {busy, stall, mul_start}); end
    run_mul(32'd4, 32'd5, d, s, bc, pre, pa, got, exp, ba, da);
    n_cmp++; if (s !== 1) begin n_err++; $display("[TB] FAIL b2b_second_start got %0d want 1", s); end
    n_cmp++; if (got !== exp) begin n_err++; $display("[TB] FAIL b2b_second got %h want %h", got, exp); end
  endtask

  initial begin
    $display("[TB] mul_seq_ctrl bench, LATENCY=%0d", LAT);
    test_reset();
    test_basic();
    test_max();
    test_read_stall();
    test_idle_combo();
    test_mt_flush();
    test_reset_mid();
    test_back_to_back();
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("[TB] FAIL sb_empty got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
